// File: rtl/adsd_risc_pkg.sv
// adsd_risc_pkg: shared types and instruction-class helpers for the ADSD RISC control sequencer
package adsd_risc_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_ADDI,
    OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLT, OP_J, OP_NOP, OP_HALT
  } opcode_e;
  typedef enum logic [3:0] {
    ALU_ADD = 4'h0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL
  } aluop_e;
  typedef enum logic [2:0] {
    IDLE = 3'd0, FETCH, DECODE, EXEC, MEM, WB, HALTED
  } state_e;
  typedef enum logic [2:0] {
    CL_ALU = 3'd0, CL_MEM, CL_BRANCH, CL_JUMP, CL_NOP, CL_HALT
  } class_e;
  function automatic logic is_rtype(input logic [3:0] op);
    return op <= 4'h6;
  endfunction
  function automatic logic is_branch(input logic [3:0] op);
    return op == OP_BEQ || op == OP_BNE || op == OP_BLT;
  endfunction
  function automatic logic is_mem(input logic [3:0] op);
    return op == OP_LW || op == OP_SW;
  endfunction
endpackage

// File: rtl/adsd_risc_decode.sv
// adsd_risc_decode: combinational opcode decode into ALU controls and instruction class
module adsd_risc_decode
  import adsd_risc_pkg::*;
(
  input  logic [3:0] opcode,
  output aluop_e     aluop,
  output logic       alu_in2_sel,
  output logic       rf_rd_sel,
  output logic       wdata_sel,
  output class_e     op_class
);
  always_comb begin
    aluop       = is_rtype(opcode) ? aluop_e'(opcode) : is_branch(opcode) ? ALU_SUB : ALU_ADD;
    alu_in2_sel = opcode == OP_ADDI || is_mem(opcode);
    rf_rd_sel   = is_rtype(opcode);
    wdata_sel   = opcode != OP_LW;
    op_class    = is_rtype(opcode) || opcode == OP_ADDI ? CL_ALU :
                  is_mem(opcode)    ? CL_MEM    :
                  is_branch(opcode) ? CL_BRANCH :
                  opcode == OP_J    ? CL_JUMP   :
                  opcode == OP_NOP  ? CL_NOP    : CL_HALT;
  end
endmodule

// File: rtl/adsd_risc_ctrl.sv
// adsd_risc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with run/step, halt, retire counter and sticky overflow
module adsd_risc_ctrl
  import adsd_risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             neg,
  input  logic             ovf,
  output logic             pc_ld,
  output logic             ctrl_branch,
  output logic             ctrl_jump,
  output logic             ctrl_i_mem_oe,
  output logic             ctrl_rf_rd_sel,
  output logic             ctrl_rf_write_en,
  output logic             ctrl_alu_in2_sel,
  output logic             ctrl_d_mem_rw_,
  output logic             ctrl_d_mem_cs,
  output logic             ctrl_wdata_sel,
  output logic [3:0]       ctrl_aluop,
  output logic             halted,
  output logic             busy,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] instr_count,
  output logic [2:0]       state_dbg
);
  state_e state, state_n, end_st;
  aluop_e dec_aluop;
  class_e cls;
  logic   dec_in2, dec_rd, dec_wdata, in_dp;
  adsd_risc_decode u_dec (
    .opcode     (opcode),
    .aluop      (dec_aluop),
    .alu_in2_sel(dec_in2),
    .rf_rd_sel  (dec_rd),
    .wdata_sel  (dec_wdata),
    .op_class   (cls)
  );
  assign end_st = run ? FETCH : IDLE;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = run || step ? FETCH : IDLE;
      FETCH:   state_n = DECODE;
      DECODE:  state_n = cls == CL_HALT ? HALTED : cls == CL_JUMP || cls == CL_NOP ? end_st : EXEC;
      EXEC:    state_n = cls == CL_BRANCH ? end_st : cls == CL_MEM ? MEM : WB;
      MEM:     state_n = opcode == OP_LW ? WB : end_st;
      WB:      state_n = end_st;
      HALTED:  state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    in_dp            = state == EXEC || state == MEM || state == WB;
    pc_ld            = (state == DECODE && (cls == CL_JUMP || cls == CL_NOP)) ||
                       (state == EXEC && cls == CL_BRANCH) ||
                       (state == MEM && opcode == OP_SW) || state == WB;
    ctrl_jump        = state == DECODE && cls == CL_JUMP;
    ctrl_branch      = state == EXEC && cls == CL_BRANCH &&
                       (opcode == OP_BEQ ? zero : opcode == OP_BNE ? !zero : neg);
    ctrl_i_mem_oe    = state == FETCH || state == DECODE || in_dp;
    ctrl_aluop       = in_dp ? dec_aluop : ALU_ADD;
    ctrl_alu_in2_sel = in_dp && dec_in2;
    ctrl_rf_rd_sel   = in_dp && dec_rd;
    ctrl_rf_write_en = state == WB;
    ctrl_wdata_sel   = state == WB && dec_wdata;
    ctrl_d_mem_cs    = state == MEM;
    ctrl_d_mem_rw_   = !(state == MEM && opcode == OP_SW);
    halted           = state == HALTED;
    busy             = state != IDLE && state != HALTED;
    state_dbg        = state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      instr_count <= '0;
      ovf_sticky  <= 1'b0;
    end else begin
      if (pc_ld) instr_count <= instr_count + CNT_W'(1);
      if (state == WB && ovf && (opcode == OP_ADD || opcode == OP_SUB || opcode == OP_ADDI)) ovf_sticky <= 1'b1;
    end
endmodule

// File: tb/tb_adsd_risc_ctrl.sv
// tb_adsd_risc_ctrl: directed self-checking bench for the ADSD RISC control sequencer
module tb_adsd_risc_ctrl;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, step = 1'b0, zero = 1'b0, neg = 1'b0, ovf = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic pc_ld, ctrl_branch, ctrl_jump, ctrl_i_mem_oe, ctrl_rf_rd_sel, ctrl_rf_write_en;
  logic ctrl_alu_in2_sel, ctrl_d_mem_rw_, ctrl_d_mem_cs, ctrl_wdata_sel, halted, busy, ovf_sticky;
  logic [3:0] ctrl_aluop;
  logic [15:0] instr_count;
  logic [2:0] state_dbg;
  logic s_pc_ld, s_branch, s_jump, s_oe, s_rd_sel, s_we, s_in2, s_rw, s_cs, s_wsel, s_halted, s_busy, s_ovf;
  logic [3:0] s_aluop, s_cnt;
  logic [2:0] s_state;
  int n_checks = 0, n_fail = 0;
  always #5 clk = ~clk;
  adsd_risc_ctrl dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode), .zero(zero), .neg(neg), .ovf(ovf),
    .pc_ld(pc_ld), .ctrl_branch(ctrl_branch), .ctrl_jump(ctrl_jump), .ctrl_i_mem_oe(ctrl_i_mem_oe),
    .ctrl_rf_rd_sel(ctrl_rf_rd_sel), .ctrl_rf_write_en(ctrl_rf_write_en), .ctrl_alu_in2_sel(ctrl_alu_in2_sel),
    .ctrl_d_mem_rw_(ctrl_d_mem_rw_), .ctrl_d_mem_cs(ctrl_d_mem_cs), .ctrl_wdata_sel(ctrl_wdata_sel),
    .ctrl_aluop(ctrl_aluop), .halted(halted), .busy(busy), .ovf_sticky(ovf_sticky),
    .instr_count(instr_count), .state_dbg(state_dbg)
  );
  adsd_risc_ctrl #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode), .zero(zero), .neg(neg), .ovf(ovf),
    .pc_ld(s_pc_ld), .ctrl_branch(s_branch), .ctrl_jump(s_jump), .ctrl_i_mem_oe(s_oe),
    .ctrl_rf_rd_sel(s_rd_sel), .ctrl_rf_write_en(s_we), .ctrl_alu_in2_sel(s_in2),
    .ctrl_d_mem_rw_(s_rw), .ctrl_d_mem_cs(s_cs), .ctrl_wdata_sel(s_wsel),
    .ctrl_aluop(s_aluop), .halted(s_halted), .busy(s_busy), .ovf_sticky(s_ovf),
    .instr_count(s_cnt), .state_dbg(s_state)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick;
    tick;
    check("rst_state", state_dbg, 0);
    check("rst_cnt", instr_count, 0);
    check("rst_rw", ctrl_d_mem_rw_, 1);
    check("rst_aluop", ctrl_aluop, 0);
    check("rst_oe", ctrl_i_mem_oe, 0);
    check("rst_busy", busy, 0);
    // reset in the middle of an ADD
    rst = 1'b0; run = 1'b1; opcode = 4'h0;
    tick; check("add0_fetch", state_dbg, 1);
    tick; tick;
    check("add0_exec", state_dbg, 3);
    rst = 1'b1; run = 1'b0;
    tick;
    check("midrst_state", state_dbg, 0);
    check("midrst_we", ctrl_rf_write_en, 0);
    check("midrst_pcld", pc_ld, 0);
    check("midrst_cnt", instr_count, 0);
    rst = 1'b0;
    tick; check("idle_hold", state_dbg, 0);
    // ADD with overflow
    run = 1'b1; ovf = 1'b1;
    tick; check("add_oe", ctrl_i_mem_oe, 1);
    check("add_f_pcld", pc_ld, 0);
    tick; tick;
    check("add_exec_aluop", ctrl_aluop, 0);
    check("add_exec_rdsel", ctrl_rf_rd_sel, 1);
    check("add_exec_we", ctrl_rf_write_en, 0);
    tick;
    check("add_wb_state", state_dbg, 5);
    check("add_wb_we", ctrl_rf_write_en, 1);
    check("add_wb_rdsel", ctrl_rf_rd_sel, 1);
    check("add_wb_wsel", ctrl_wdata_sel, 1);
    check("add_wb_pcld", pc_ld, 1);
    check("add_wb_cnt", instr_count, 0);
    tick;
    check("add_cnt", instr_count, 1);
    check("add_sticky", ovf_sticky, 1);
    check("add_next_fetch", state_dbg, 1);
    // LW
    opcode = 4'h8; ovf = 1'b0;
    tick; tick;
    check("lw_exec_aluop", ctrl_aluop, 0);
    check("lw_exec_in2", ctrl_alu_in2_sel, 1);
    check("lw_exec_cs", ctrl_d_mem_cs, 0);
    tick;
    check("lw_mem_cs", ctrl_d_mem_cs, 1);
    check("lw_mem_rw", ctrl_d_mem_rw_, 1);
    check("lw_mem_we", ctrl_rf_write_en, 0);
    check("lw_mem_pcld", pc_ld, 0);
    check("lw_mem_in2", ctrl_alu_in2_sel, 1);
    tick;
    check("lw_wb_we", ctrl_rf_write_en, 1);
    check("lw_wb_wsel", ctrl_wdata_sel, 0);
    check("lw_wb_rdsel", ctrl_rf_rd_sel, 0);
    check("lw_wb_cs", ctrl_d_mem_cs, 0);
    check("lw_wb_pcld", pc_ld, 1);
    check("lw_wb_in2", ctrl_alu_in2_sel, 1);
    tick; check("lw_cnt", instr_count, 2);
    // BEQ taken, BEQ not taken, BLT taken with run dropped mid-instruction
    opcode = 4'hA; zero = 1'b1;
    tick; tick;
    check("beq1_pcld", pc_ld, 1);
    check("beq1_branch", ctrl_branch, 1);
    check("beq1_aluop", ctrl_aluop, 1);
    tick; check("beq1_cnt", instr_count, 3);
    zero = 1'b0;
    tick; tick;
    check("beq0_pcld", pc_ld, 1);
    check("beq0_branch", ctrl_branch, 0);
    tick; check("beq0_cnt", instr_count, 4);
    opcode = 4'hC; neg = 1'b1;
    tick; run = 1'b0;
    tick;
    check("blt_branch", ctrl_branch, 1);
    check("blt_pcld", pc_ld, 1);
    tick;
    check("blt_idle", state_dbg, 0);
    check("blt_cnt", instr_count, 5);
    check("blt_busy", busy, 0);
    neg = 1'b0;
    // SW by single step, second step while busy ignored
    opcode = 4'h9; step = 1'b1;
    tick; step = 1'b0;
    check("sw_fetch", state_dbg, 1);
    check("sw_busy", busy, 1);
    tick; step = 1'b1;
    tick; step = 1'b0;
    check("sw_exec_cs", ctrl_d_mem_cs, 0);
    check("sw_exec_rw", ctrl_d_mem_rw_, 1);
    tick;
    check("sw_mem_cs", ctrl_d_mem_cs, 1);
    check("sw_mem_rw", ctrl_d_mem_rw_, 0);
    check("sw_mem_pcld", pc_ld, 1);
    check("sw_mem_we", ctrl_rf_write_en, 0);
    tick;
    check("sw_idle", state_dbg, 0);
    check("sw_cnt", instr_count, 6);
    check("sw_rw_idle", ctrl_d_mem_rw_, 1);
    tick; check("sw_no_replay", state_dbg, 0);
    // ten NOPs drive the 4-bit counter from 6 through 15 to 0
    opcode = 4'hE; run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      tick;
      check("nop_pcld", pc_ld, 1);
      if (i == 9) run = 1'b0;
    end
    check("w4_pre_wrap", s_cnt, 15);
    tick;
    check("nop_idle", state_dbg, 0);
    check("nop_cnt", instr_count, 16);
    check("w4_wrap", s_cnt, 0);
    // J
    opcode = 4'hD; run = 1'b1;
    tick; tick;
    check("j_jump", ctrl_jump, 1);
    check("j_pcld", pc_ld, 1);
    run = 1'b0;
    tick;
    check("j_idle", state_dbg, 0);
    check("j_cnt", instr_count, 17);
    check("w4_j_cnt", s_cnt, 1);
    // HALT
    opcode = 4'hF; run = 1'b1;
    tick; tick;
    check("halt_dec_pcld", pc_ld, 0);
    check("halt_dec_halted", halted, 0);
    tick;
    check("halt_state", state_dbg, 6);
    check("halt_flag", halted, 1);
    check("halt_busy", busy, 0);
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("halt_pcld", pc_ld, 0);
      check("halt_stay", state_dbg, 6);
    end
    check("halt_cnt", instr_count, 17);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    tick;
    check("unhalt_state", state_dbg, 0);
    check("unhalt_flag", halted, 0);
    check("unhalt_sticky", ovf_sticky, 0);
    check("unhalt_cnt", instr_count, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
